sha_mem_responder: RTL
======================

Name: sha_mem_responder

Overview:
- Word-addressed memory responder on the far side of the SHA-256 engine's memory interface.
- Serves engine reads and writes (mem_we/mem_addr/mem_write_data/mem_read_data).
- Provides a host-side streaming loader that preloads message words before the engine starts.
- Captures the 8-word hash the engine writes to an output window and presents it as one 256-bit result with a sticky valid.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words; must be a power of 2; AW = $clog2(MEM_DEPTH).
- HASH_WORDS, 8, number of words in the captured result window.

Ports:
- clk  in  1  single clock; the engine's mem_clk is this same clock.
- reset_n  in  1  asynchronous active-low reset.
- mem_we  in  1  engine write enable.
- mem_addr  in  16  engine word address; only the low AW bits are used, so addresses wrap modulo MEM_DEPTH.
- mem_write_data  in  32  engine write data.
- mem_read_data  out  32  read data returned to the engine.
- load_start  in  1  one-cycle pulse that begins a preload.
- load_base  in  16  first word address of the preload; sampled on load_start.
- load_len  in  16  number of words to preload; sampled on load_start.
- load_valid  in  1  load word valid.
- load_data  in  32  load word.
- load_ready  out  1  responder accepts load_data this cycle.
- out_base  in  16  base of the hash window; sampled on leaving LOAD.
- hash_valid  out  1  sticky; all HASH_WORDS words have been captured.
- hash_out  out  256  captured hash; word 0 (at out_base) in bits [255:224].
- hash_clear  in  1  clears hash_valid and the capture mask, then returns to IDLE.
- busy  out  1  high in LOAD.

Behaviour:
- Reset values: mem_read_data=0, load_ready=0, hash_valid=0, hash_out=0, busy=0, state=IDLE, capture mask=0. Memory contents are not reset.
- Read path: registered. mem_read_data is updated every cycle with mem[mem_addr[AW-1:0]], giving 1-cycle latency.
  - Read of an address being written in the same cycle returns the old data (read-before-write).
- Write port: single port, engine has priority.
  - If mem_we=1, the engine write is performed.
  - An engine write in any state other than LOAD is always committed to memory.
- States:
  - IDLE: load_ready=0. load_start -> LOAD; ptr<=load_base, remaining<=load_len.
    - If load_len=0, go straight to ARMED instead.
  - LOAD: busy=1; load_ready = !mem_we.
    - A word is accepted when load_valid && load_ready: mem[ptr]<=load_data, ptr<=ptr+1 (wraps modulo MEM_DEPTH), remaining--.
    - Accepting the last word -> ARMED; out_base is latched on that transition.
    - An engine write during LOAD stalls the loader for that cycle; the engine write is committed.
    - load_start is ignored while in LOAD.
  - ARMED: every engine write with (mem_addr - out_base_latched) mod MEM_DEPTH < HASH_WORDS also updates hash word [idx] and sets mask[idx].
    - Writes to the same idx twice overwrite; the latest value wins.
    - When the mask becomes all ones -> DONE, with hash_valid=1 in the same cycle hash_out holds the final word.
  - DONE: hash_valid held at 1; hash_out frozen; further engine writes still go to memory but not to hash_out.
  - hash_clear in ARMED or DONE -> IDLE; mask=0; hash_valid=0; hash_out retained.
  - load_start in ARMED or DONE behaves as in IDLE, and the mask is cleared.
  - hash_clear and load_start in the same cycle: hash_clear wins.
- Reset asserted mid-operation: immediate return to reset values; a partial load is abandoned.
- Address arithmetic is always modulo MEM_DEPTH; no out-of-range error.

Optional Feature:
- RD_PIPE_EN
  - Defined: adds a second output register, so read latency is 2 cycles. Read-before-write semantics are unchanged; the engine's 2-cycle read window still works.
  - Undefined: read latency is 1 cycle.
- The hash capture path is unaffected either way.

Decomposition:
- Package sha_mem_pkg holds:
  - state enum {IDLE, LOAD, ARMED, DONE};
  - HASH_WORDS;
  - the 256-bit hash typedef;
  - a word typedef logic [31:0].
- Sub-module sha_mem_ram: the synchronous RAM (single write port, registered read, optional RD_PIPE_EN stage).
- The top-level block holds the FSM, loader and capture logic.

Test Plan:
- Reset, then load_base=0, load_len=20, words 0x01..0x14 -> load_ready=1 each cycle; state reaches ARMED after 20 accepts; engine reads of addr 5 return 0x06 one cycle later (two cycles with RD_PIPE_EN).
- Engine writes 0xA..0xH pattern to out_base=0x100..0x107 in order -> hash_valid rises on the 8th write cycle; hash_out = {w0..w7}.
- Out-of-order hash writes (7,0,3,...) plus a duplicate write to idx 2 -> hash_valid only after all 8; idx 2 holds the latest value.
- Engine mem_we=1 during a LOAD accept cycle -> load_ready=0 that cycle, engine data committed, load resumes and the final contents are correct.
- load_base=MEM_DEPTH-2, load_len=4 -> words land at 254,255,0,1.
- reset_n pulsed low mid-LOAD -> outputs return to 0; hash_clear in DONE -> hash_valid=0, state IDLE.

Source files
------------

// File: rtl/sha_mem_pkg.sv
// Shared types for the SHA-256 memory responder.
package sha_mem_pkg;

    localparam int HASH_WORDS = 8;

    typedef logic [31:0]              word_t;
    typedef logic [HASH_WORDS*32-1:0] hash_t;

    typedef enum logic [1:0] {IDLE, LOAD, ARMED, DONE} state_t;

endpackage

// File: rtl/sha_mem_ram.sv
// Single-write-port RAM with registered read. The read is read-before-write.
// Define RD_PIPE_EN to add a second output register (2-cycle read latency).
module sha_mem_ram
    import sha_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata,
    input  logic [AW-1:0] raddr,
    output word_t         rdata
);

    word_t mem [MEM_DEPTH];
    word_t rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[raddr];
        end
    end

`ifdef RD_PIPE_EN
    word_t rd_q2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q2 <= '0;
        end else begin
            rd_q2 <= rd_q;
        end
    end

    assign rdata = rd_q2;
`else
    assign rdata = rd_q;
`endif

endmodule

// File: rtl/sha_mem_responder.sv
// Memory responder for the SHA-256 engine: host preload, engine read/write, hash capture.
// Build option RD_PIPE_EN selects a 2-cycle read latency in the RAM.
module sha_mem_responder
    import sha_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_we,
    input  logic [15:0]  mem_addr,
    input  logic [31:0]  mem_write_data,
    output logic [31:0]  mem_read_data,
    input  logic         load_start,
    input  logic [15:0]  load_base,
    input  logic [15:0]  load_len,
    input  logic         load_valid,
    input  logic [31:0]  load_data,
    output logic         load_ready,
    input  logic [15:0]  out_base,
    output logic         hash_valid,
    output logic [255:0] hash_out,
    input  logic         hash_clear,
    output logic         busy
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int HW = $clog2(HASH_WORDS);

    state_t                state;
    logic [AW-1:0]         ptr;
    logic [AW-1:0]         out_base_q;
    logic [15:0]           remaining;
    logic [HASH_WORDS-1:0] mask;
    word_t                 hash_w [HASH_WORDS];

    logic                  load_acc;
    logic                  clear_now;
    logic                  start_now;
    logic [AW-1:0]         eng_addr;
    logic [AW-1:0]         win_idx;
    logic [HW-1:0]         hidx;
    logic [HASH_WORDS-1:0] hit;
    logic [HASH_WORDS-1:0] mask_next;
    logic                  ram_we;
    logic [AW-1:0]         ram_waddr;
    word_t                 ram_wdata;
    logic                  unused_hi;

    assign unused_hi = ^{mem_addr[15:AW], load_base[15:AW], out_base[15:AW]};

    assign eng_addr   = mem_addr[AW-1:0];
    assign load_ready = (state == LOAD) && !mem_we;
    assign busy       = (state == LOAD);
    assign load_acc   = load_valid && load_ready;

    // hash_clear beats load_start; both are only meaningful outside LOAD
    assign clear_now = hash_clear && ((state == ARMED) || (state == DONE));
    assign start_now = load_start && (state != LOAD) && !clear_now;

    // window offset wraps with the memory, so a window may straddle address 0
    assign win_idx   = eng_addr - out_base_q;
    assign hidx      = win_idx[HW-1:0];
    assign mask_next = mask | hit;

    always_comb begin
        hit = '0;
        if (mem_we && (state == ARMED) && (int'(win_idx) < HASH_WORDS)) begin
            hit[hidx] = 1'b1;
        end
    end

    always_comb begin
        hash_out = '0;
        for (int i = 0; i < HASH_WORDS; i++) begin
            hash_out[(HASH_WORDS-1-i)*32 +: 32] = hash_w[i];
        end
    end

    assign ram_we    = mem_we || load_acc;
    assign ram_waddr = mem_we ? eng_addr : ptr;
    assign ram_wdata = mem_we ? mem_write_data : load_data;

    sha_mem_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr   (eng_addr),
        .rdata   (mem_read_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            out_base_q <= '0;
            remaining  <= '0;
            mask       <= '0;
            hash_valid <= 1'b0;
            for (int i = 0; i < HASH_WORDS; i++) begin
                hash_w[i] <= '0;
            end
        end else if (clear_now) begin
            state      <= IDLE;
            mask       <= '0;
            hash_valid <= 1'b0;
        end else if (start_now) begin
            ptr       <= load_base[AW-1:0];
            remaining <= load_len;
            mask      <= '0;
            if (load_len == 16'd0) begin
                state      <= ARMED;
                out_base_q <= out_base[AW-1:0];
            end else begin
                state <= LOAD;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (load_acc) begin
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state      <= ARMED;
                            out_base_q <= out_base[AW-1:0];
                        end
                    end
                end
                ARMED: begin
                    if (|hit) begin
                        hash_w[hidx] <= mem_write_data;
                        mask         <= mask_next;
                        if (&mask_next) begin
                            state      <= DONE;
                            hash_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
